z80fi_retire_packer: RTL
========================

Name: z80fi_retire_packer

Overview:
- Producer end of the Z80FI formal interface. Sits beside the core datapath and samples per-M-cycle events: opcode/operand fetches, register writes, memory reads/writes and flag writes.
- At instruction completion it emits exactly one one-cycle z80fi_valid retire packet.
- The insn_spec checkers and the formal harness consume that packet.

Parameters:
- MAX_INSN_BYTES, 4, instruction byte capacity (z80fi_insn width = 8*MAX_INSN_BYTES).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ev_insn_start  in  1  first M1 fetch of a new instruction this cycle
- ev_pc  in  16  PC of that instruction (valid with ev_insn_start)
- ev_fetch  in  1  instruction byte fetched (opcode, prefix, displacement or immediate)
- ev_fetch_byte  in  8  fetched byte
- ev_reg_wr  in  1  register-file write
- ev_reg_wnum  in  4  register number
- ev_reg_wdata  in  16  register write data
- ev_mem_rd  in  1  data memory read
- ev_mem_wr  in  1  data memory write
- ev_mem_addr  in  16  memory address
- ev_mem_data  in  8  read or write data
- ev_f_wr  in  1  flag write
- ev_f_wdata  in  8  new F
- ev_insn_done  in  1  last cycle of the instruction
- ev_pc_next  in  16  next PC (valid with ev_insn_done)
- z80fi_valid  out  1  retire pulse
- z80fi_insn  out  32  instruction bytes; byte 0 in [7:0]
- z80fi_insn_len  out  3  bytes fetched
- z80fi_pc_rdata, z80fi_pc_wdata  out  16 each
- z80fi_reg_wr  out  1
- z80fi_reg_wnum  out  4
- z80fi_reg_wdata  out  16
- z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2  out  1 each
- z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_waddr, z80fi_mem_waddr2  out  16 each
- z80fi_mem_rdata, z80fi_mem_rdata2, z80fi_mem_wdata, z80fi_mem_wdata2  out  8 each
- z80fi_f_wr  out  1
- z80fi_f_wdata  out  8
- z80fi_overflow  out  1  packet dropped events (sticky per packet)

Behaviour:
- Reset: all outputs 0. State goes to IDLE. Accumulators are cleared.
- Two states: IDLE and COLLECT.
  - IDLE to COLLECT on ev_insn_start.
  - COLLECT to IDLE on ev_insn_done without ev_insn_start.
  - COLLECT stays in COLLECT on ev_insn_done with ev_insn_start (back-to-back instructions).
- On ev_insn_start:
  - Clear the accumulator and latch pc_rdata = ev_pc.
  - A fetch in the same cycle is recorded as byte 0.
- ev_fetch writes ev_fetch_byte into slot insn_len and increments insn_len.
  - A 5th byte is dropped and sets overflow. insn_len saturates at 4.
  - Unused insn bytes read as 0.
- Memory reads:
  - First ev_mem_rd fills the rd slot; second fills rd2; a third sets overflow.
  - Writes fill wr and wr2 the same way.
- ev_reg_wr: last write wins and reg_wr=1. A second write in one instruction also sets overflow.
- ev_f_wr: last write wins.
- Events outside COLLECT (IDLE with no ev_insn_start) are ignored. They do not set overflow.
- Same-cycle events: events coincident with ev_insn_done belong to the retiring instruction.
  - Exception: when ev_insn_start is also high, that cycle's ev_fetch belongs to the new instruction. All other events belong to the old one.
- Retire timing:
  - The cycle after ev_insn_done, z80fi_valid=1 for exactly one cycle.
  - All z80fi_* fields hold the completed packet, with pc_wdata = ev_pc_next latched at done.
  - Outputs are registered; latency is 1 cycle from done.
  - Fields hold their values while valid=0 until the next retire.
- ev_insn_done in IDLE is ignored: no pulse.
- Reset mid-instruction discards the packet and produces no pulse. Reset coincident with the retire cycle forces valid=0.

Decomposition:
- z80fi.vh: Z80FI field widths and port macros.
- z80.vh: register-number constants (e.g. REG_PC, REG_F).
- One natural sub-module: z80fi_mem_slot2. It is a two-entry "first/second" capture with overflow and is instantiated twice (reads, writes).

Test Plan:
- LD B,0x5A: start pc=0x0100, fetch 0x06, 0x5A, reg_wr num=0 data=0x005A, done pc_next=0x0102 -> one valid pulse, insn=0x00005A06, len=2, reg_wnum=0, reg_wdata=0x005A, mem_* all 0.
- EX (SP),HL at pc=0x2000: two reads (0x8000→0x34, 0x8001→0x12), two writes -> rd/rd2 and wr/wr2 in order, addresses/data exact, overflow=0.
- Back-to-back: done of NOP at 0x0000 coincident with start+fetch 0x3E of next at 0x0001 -> first packet insn=0x00, len=1. Second packet byte0=0x3E, pc_rdata=0x0001.
- 5 fetches (DD CB d 06 xx) -> len=4, first four bytes kept, overflow=1. A third mem read -> overflow=1.
- Reset asserted after 1 fetch -> no valid pulse, all outputs 0. Next instruction retires cleanly.
- ev_insn_done and stray ev_mem_rd while IDLE -> no pulse, overflow stays 0.

Source files
------------

// File: rtl/z80fi_retire_packer_pkg.sv
// Shared types and field widths for the Z80FI retire packer.
// Register numbers are the values carried on ev_reg_wnum / z80fi_reg_wnum.
package z80fi_retire_packer_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int REG_W    = 16;
  localparam int REGNUM_W = 4;
  localparam int LEN_W    = 3;

  localparam logic [REGNUM_W-1:0] REG_B  = 4'd0;
  localparam logic [REGNUM_W-1:0] REG_A  = 4'd7;
  localparam logic [REGNUM_W-1:0] REG_HL = 4'd8;
  localparam logic [REGNUM_W-1:0] REG_F  = 4'd9;
  localparam logic [REGNUM_W-1:0] REG_PC = 4'd10;

endpackage

// File: rtl/z80fi_retire_packer_if.sv
// Core-event inputs and retire-packet outputs of the packer.
// master = core/event source, slave = the packer.
interface z80fi_retire_packer_if
  import z80fi_retire_packer_pkg::*;
#(
  parameter int MAX_INSN_BYTES = 4
);
  logic                    ev_insn_start;
  logic [ADDR_W-1:0]       ev_pc;
  logic                    ev_fetch;
  logic [DATA_W-1:0]       ev_fetch_byte;
  logic                    ev_reg_wr;
  logic [REGNUM_W-1:0]     ev_reg_wnum;
  logic [REG_W-1:0]        ev_reg_wdata;
  logic                    ev_mem_rd;
  logic                    ev_mem_wr;
  logic [ADDR_W-1:0]       ev_mem_addr;
  logic [DATA_W-1:0]       ev_mem_data;
  logic                    ev_f_wr;
  logic [DATA_W-1:0]       ev_f_wdata;
  logic                    ev_insn_done;
  logic [ADDR_W-1:0]       ev_pc_next;

  logic                        z80fi_valid;
  logic [8*MAX_INSN_BYTES-1:0] z80fi_insn;
  logic [LEN_W-1:0]            z80fi_insn_len;
  logic [ADDR_W-1:0]           z80fi_pc_rdata;
  logic [ADDR_W-1:0]           z80fi_pc_wdata;
  logic                        z80fi_reg_wr;
  logic [REGNUM_W-1:0]         z80fi_reg_wnum;
  logic [REG_W-1:0]            z80fi_reg_wdata;
  logic                        z80fi_mem_rd;
  logic                        z80fi_mem_rd2;
  logic                        z80fi_mem_wr;
  logic                        z80fi_mem_wr2;
  logic [ADDR_W-1:0]           z80fi_mem_raddr;
  logic [ADDR_W-1:0]           z80fi_mem_raddr2;
  logic [ADDR_W-1:0]           z80fi_mem_waddr;
  logic [ADDR_W-1:0]           z80fi_mem_waddr2;
  logic [DATA_W-1:0]           z80fi_mem_rdata;
  logic [DATA_W-1:0]           z80fi_mem_rdata2;
  logic [DATA_W-1:0]           z80fi_mem_wdata;
  logic [DATA_W-1:0]           z80fi_mem_wdata2;
  logic                        z80fi_f_wr;
  logic [DATA_W-1:0]           z80fi_f_wdata;
  logic                        z80fi_overflow;

  modport master (
    output ev_insn_start, ev_pc, ev_fetch, ev_fetch_byte, ev_reg_wr, ev_reg_wnum,
           ev_reg_wdata, ev_mem_rd, ev_mem_wr, ev_mem_addr, ev_mem_data, ev_f_wr,
           ev_f_wdata, ev_insn_done, ev_pc_next,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
           z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata, z80fi_mem_rd, z80fi_mem_rd2,
           z80fi_mem_wr, z80fi_mem_wr2, z80fi_mem_raddr, z80fi_mem_raddr2,
           z80fi_mem_waddr, z80fi_mem_waddr2, z80fi_mem_rdata, z80fi_mem_rdata2,
           z80fi_mem_wdata, z80fi_mem_wdata2, z80fi_f_wr, z80fi_f_wdata, z80fi_overflow
  );

  modport slave (
    input  ev_insn_start, ev_pc, ev_fetch, ev_fetch_byte, ev_reg_wr, ev_reg_wnum,
           ev_reg_wdata, ev_mem_rd, ev_mem_wr, ev_mem_addr, ev_mem_data, ev_f_wr,
           ev_f_wdata, ev_insn_done, ev_pc_next,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
           z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata, z80fi_mem_rd, z80fi_mem_rd2,
           z80fi_mem_wr, z80fi_mem_wr2, z80fi_mem_raddr, z80fi_mem_raddr2,
           z80fi_mem_waddr, z80fi_mem_waddr2, z80fi_mem_rdata, z80fi_mem_rdata2,
           z80fi_mem_wdata, z80fi_mem_wdata2, z80fi_f_wr, z80fi_f_wdata, z80fi_overflow
  );
endinterface

// File: rtl/z80fi_retire_packer_mem_slot2.sv
// Two-entry first/second capture of memory accesses with overflow flag.
// Outputs are the "merged" view: stored state plus this cycle's old_hit.
module z80fi_mem_slot2
  import z80fi_retire_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              old_hit,
  input  logic              new_hit,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              v1,
  output logic [ADDR_W-1:0] a1,
  output logic [DATA_W-1:0] d1,
  output logic              v2,
  output logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] d2,
  output logic              ovf
);
  logic              v1_reg, v2_reg, ovf_reg;
  logic [ADDR_W-1:0] a1_reg, a2_reg;
  logic [DATA_W-1:0] d1_reg, d2_reg;
  logic              v1_next, v2_next, ovf_next;
  logic [ADDR_W-1:0] a1_next, a2_next;
  logic [DATA_W-1:0] d1_next, d2_next;

  always_comb begin
    v1 = v1_reg; a1 = a1_reg; d1 = d1_reg;
    v2 = v2_reg; a2 = a2_reg; d2 = d2_reg;
    ovf = ovf_reg;
    if (old_hit) begin
      if (!v1_reg) begin
        v1 = 1'b1; a1 = addr; d1 = data;
      end else if (!v2_reg) begin
        v2 = 1'b1; a2 = addr; d2 = data;
      end else begin
        ovf = 1'b1;
      end
    end
  end

  // A new instruction starts empty, optionally with its first access already in slot 1.
  always_comb begin
    v1_next = v1; a1_next = a1; d1_next = d1;
    v2_next = v2; a2_next = a2; d2_next = d2;
    ovf_next = ovf;
    if (clear) begin
      v1_next = new_hit;
      a1_next = new_hit ? addr : '0;
      d1_next = new_hit ? data : '0;
      v2_next = 1'b0; a2_next = '0; d2_next = '0;
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg <= 1'b0; a1_reg <= '0; d1_reg <= '0;
      v2_reg <= 1'b0; a2_reg <= '0; d2_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      v1_reg <= v1_next; a1_reg <= a1_next; d1_reg <= d1_next;
      v2_reg <= v2_next; a2_reg <= a2_next; d2_reg <= d2_next;
      ovf_reg <= ovf_next;
    end
  end
endmodule

// File: rtl/z80fi_retire_packer.sv
// Collects per-M-cycle core events and emits one registered Z80FI retire packet
// the cycle after ev_insn_done.
module z80fi_retire_packer
  import z80fi_retire_packer_pkg::*;
#(
  parameter int MAX_INSN_BYTES = 4
)
(
  input  logic                  clk,
  input  logic                  reset,
  z80fi_retire_packer_if.slave  bus
);
  localparam int INSN_W = 8 * MAX_INSN_BYTES;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_INSN_BYTES);

  state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (bus.ev_insn_start) state_next = ST_COLLECT;
      ST_COLLECT: if (bus.ev_insn_done && !bus.ev_insn_start) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  logic collect, start, retire, old_fetch, new_fetch, new_other;
  assign collect   = (state_reg == ST_COLLECT);
  assign start     = bus.ev_insn_start;
  assign retire    = collect && bus.ev_insn_done;
  // On a start+done cycle only the fetch moves to the new instruction.
  assign old_fetch = collect && bus.ev_fetch && !start;
  assign new_fetch = start && bus.ev_fetch;
  assign new_other = start && !retire;

  logic [INSN_W-1:0]   insn_reg, insn_merged, insn_next;
  logic [LEN_W-1:0]    len_reg, len_merged, len_next;
  logic [ADDR_W-1:0]   pc_rdata_reg, pc_rdata_next;
  logic                reg_wr_reg, reg_wr_merged, reg_wr_next;
  logic [REGNUM_W-1:0] wnum_reg, wnum_merged, wnum_next;
  logic [REG_W-1:0]    wdata_reg, wdata_merged, wdata_next;
  logic                f_wr_reg, f_wr_merged, f_wr_next;
  logic [DATA_W-1:0]   f_wdata_reg, f_wdata_merged, f_wdata_next;
  logic                ovf_reg, ovf_merged, ovf_next;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_INSN_BYTES; gi++) begin : g_byte
      assign insn_merged[gi*8 +: 8] = (old_fetch && len_reg == LEN_W'(gi)) ?
                                      bus.ev_fetch_byte : insn_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    len_merged     = len_reg;
    ovf_merged     = ovf_reg;
    reg_wr_merged  = reg_wr_reg;
    wnum_merged    = wnum_reg;
    wdata_merged   = wdata_reg;
    f_wr_merged    = f_wr_reg;
    f_wdata_merged = f_wdata_reg;
    if (old_fetch) begin
      if (len_reg < LEN_MAX) len_merged = len_reg + LEN_W'(1);
      else                   ovf_merged = 1'b1;
    end
    if (collect && bus.ev_reg_wr) begin
      reg_wr_merged = 1'b1;
      wnum_merged   = bus.ev_reg_wnum;
      wdata_merged  = bus.ev_reg_wdata;
      if (reg_wr_reg) ovf_merged = 1'b1;
    end
    if (collect && bus.ev_f_wr) begin
      f_wr_merged    = 1'b1;
      f_wdata_merged = bus.ev_f_wdata;
    end
  end

  always_comb begin
    insn_next     = insn_merged;
    len_next      = len_merged;
    pc_rdata_next = pc_rdata_reg;
    reg_wr_next   = reg_wr_merged;
    wnum_next     = wnum_merged;
    wdata_next    = wdata_merged;
    f_wr_next     = f_wr_merged;
    f_wdata_next  = f_wdata_merged;
    ovf_next      = ovf_merged;
    if (start) begin
      insn_next      = '0;
      insn_next[7:0] = new_fetch ? bus.ev_fetch_byte : 8'h00;
      len_next       = new_fetch ? LEN_W'(1) : '0;
      pc_rdata_next  = bus.ev_pc;
      reg_wr_next    = new_other && bus.ev_reg_wr;
      wnum_next      = (new_other && bus.ev_reg_wr) ? bus.ev_reg_wnum : '0;
      wdata_next     = (new_other && bus.ev_reg_wr) ? bus.ev_reg_wdata : '0;
      f_wr_next      = new_other && bus.ev_f_wr;
      f_wdata_next   = (new_other && bus.ev_f_wr) ? bus.ev_f_wdata : '0;
      ovf_next       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      insn_reg <= '0; len_reg <= '0; pc_rdata_reg <= '0;
      reg_wr_reg <= 1'b0; wnum_reg <= '0; wdata_reg <= '0;
      f_wr_reg <= 1'b0; f_wdata_reg <= '0; ovf_reg <= 1'b0;
    end else begin
      insn_reg <= insn_next; len_reg <= len_next; pc_rdata_reg <= pc_rdata_next;
      reg_wr_reg <= reg_wr_next; wnum_reg <= wnum_next; wdata_reg <= wdata_next;
      f_wr_reg <= f_wr_next; f_wdata_reg <= f_wdata_next; ovf_reg <= ovf_next;
    end
  end

  logic              rd_v1, rd_v2, rd_ovf, wr_v1, wr_v2, wr_ovf;
  logic [ADDR_W-1:0] rd_a1, rd_a2, wr_a1, wr_a2;
  logic [DATA_W-1:0] rd_d1, rd_d2, wr_d1, wr_d2;

  z80fi_mem_slot2 u_rd_slots (
    .clk(clk), .reset(reset), .clear(start),
    .old_hit(collect && bus.ev_mem_rd), .new_hit(new_other && bus.ev_mem_rd),
    .addr(bus.ev_mem_addr), .data(bus.ev_mem_data),
    .v1(rd_v1), .a1(rd_a1), .d1(rd_d1), .v2(rd_v2), .a2(rd_a2), .d2(rd_d2), .ovf(rd_ovf)
  );

  z80fi_mem_slot2 u_wr_slots (
    .clk(clk), .reset(reset), .clear(start),
    .old_hit(collect && bus.ev_mem_wr), .new_hit(new_other && bus.ev_mem_wr),
    .addr(bus.ev_mem_addr), .data(bus.ev_mem_data),
    .v1(wr_v1), .a1(wr_a1), .d1(wr_d1), .v2(wr_v2), .a2(wr_a2), .d2(wr_d2), .ovf(wr_ovf)
  );

  logic valid_reg;
  // Reset landing on the retire cycle must still suppress the pulse.
  assign bus.z80fi_valid = valid_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      bus.z80fi_insn <= '0; bus.z80fi_insn_len <= '0;
      bus.z80fi_pc_rdata <= '0; bus.z80fi_pc_wdata <= '0;
      bus.z80fi_reg_wr <= 1'b0; bus.z80fi_reg_wnum <= '0; bus.z80fi_reg_wdata <= '0;
      bus.z80fi_mem_rd <= 1'b0; bus.z80fi_mem_raddr <= '0; bus.z80fi_mem_rdata <= '0;
      bus.z80fi_mem_rd2 <= 1'b0; bus.z80fi_mem_raddr2 <= '0; bus.z80fi_mem_rdata2 <= '0;
      bus.z80fi_mem_wr <= 1'b0; bus.z80fi_mem_waddr <= '0; bus.z80fi_mem_wdata <= '0;
      bus.z80fi_mem_wr2 <= 1'b0; bus.z80fi_mem_waddr2 <= '0; bus.z80fi_mem_wdata2 <= '0;
      bus.z80fi_f_wr <= 1'b0; bus.z80fi_f_wdata <= '0; bus.z80fi_overflow <= 1'b0;
    end else begin
      valid_reg <= retire;
      if (retire) begin
        bus.z80fi_insn <= insn_merged; bus.z80fi_insn_len <= len_merged;
        bus.z80fi_pc_rdata <= pc_rdata_reg; bus.z80fi_pc_wdata <= bus.ev_pc_next;
        bus.z80fi_reg_wr <= reg_wr_merged; bus.z80fi_reg_wnum <= wnum_merged;
        bus.z80fi_reg_wdata <= wdata_merged;
        bus.z80fi_mem_rd <= rd_v1; bus.z80fi_mem_raddr <= rd_a1; bus.z80fi_mem_rdata <= rd_d1;
        bus.z80fi_mem_rd2 <= rd_v2; bus.z80fi_mem_raddr2 <= rd_a2; bus.z80fi_mem_rdata2 <= rd_d2;
        bus.z80fi_mem_wr <= wr_v1; bus.z80fi_mem_waddr <= wr_a1; bus.z80fi_mem_wdata <= wr_d1;
        bus.z80fi_mem_wr2 <= wr_v2; bus.z80fi_mem_waddr2 <= wr_a2; bus.z80fi_mem_wdata2 <= wr_d2;
        bus.z80fi_f_wr <= f_wr_merged; bus.z80fi_f_wdata <= f_wdata_merged;
        bus.z80fi_overflow <= ovf_merged || rd_ovf || wr_ovf;
      end
    end
  end
endmodule
